// File: rtl/zero_scan_pkg.sv
// rtl/zero_scan_pkg.sv - shared types and sizing for the iterative zero-test scheduler
package zero_scan_pkg;

  localparam int DATA_W  = 64;
  localparam int SLICE_W = 16;
  localparam int NSLICE  = DATA_W / SLICE_W;
  localparam int IDX_W   = $clog2(NSLICE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    REQ_EX = 1'b0,
    REQ_BR = 1'b1
  } req_id_t;

endpackage

// File: rtl/nor_zero16.sv
// rtl/nor_zero16.sv - 16-bit NOR zero detector (1 = all input bits clear)
module nor_zero16 (
  input  logic [15:0] data,
  output logic        zero
);

  logic [3:0] nib_any;

  // Two gate levels: per-nibble OR, then a 4-input NOR.
  assign nib_any[0] = |data[3:0];
  assign nib_any[1] = |data[7:4];
  assign nib_any[2] = |data[11:8];
  assign nib_any[3] = |data[15:12];
  assign zero       = ~|nib_any;

endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational 2-way round-robin grant; last-grant state lives in the parent
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt
);

  // On a tie the requester that did not win last time takes the grant.
  assign gnt[0] = en & req[0] & (~req[1] | last);
  assign gnt[1] = en & req[1] & (~req[0] | ~last);

endmodule

// File: rtl/zero_scan_sched.sv
// rtl/zero_scan_sched.sv - shares one 16-bit zero detector between EX and branch clients, slice by slice
module zero_scan_sched
  import zero_scan_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_req,
  input  logic [DATA_W-1:0] ex_data,
  output logic              ex_gnt,
  output logic              ex_done,
  input  logic              br_req,
  input  logic [DATA_W-1:0] br_data,
  output logic              br_gnt,
  output logic              br_done,
  output logic              is_zero,
  output logic              busy
);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  shadow;
  req_id_t            owner;
  req_id_t            last_grant;
  logic               is_zero_r;

  logic [1:0]         gnt;
  logic [SLICE_W-1:0] det_in;
  logic               zd;

  rr_arb2 u_arb (
    .req  ({br_req, ex_req}),
    .last (last_grant == REQ_BR),
    .en   ((state == IDLE) && !reset),
    .gnt  (gnt)
  );

  // Detector sees zeros outside SCAN so it never toggles on stale shadow data.
  assign det_in = (state == SCAN) ? shadow[idx*SLICE_W +: SLICE_W] : '0;

  nor_zero16 u_det (
    .data (det_in),
    .zero (zd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      shadow     <= '0;
      owner      <= REQ_EX;
      last_grant <= REQ_BR;
      is_zero_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt[1]) begin
            shadow     <= br_data;
            owner      <= REQ_BR;
            last_grant <= REQ_BR;
            idx        <= '0;
            state      <= SCAN;
          end else if (gnt[0]) begin
            shadow     <= ex_data;
            owner      <= REQ_EX;
            last_grant <= REQ_EX;
            idx        <= '0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (!zd) begin
            is_zero_r <= 1'b0;
            state     <= DONE;
          end else if (idx == IDX_W'(NSLICE - 1)) begin
            is_zero_r <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ex_gnt  = gnt[0];
  assign br_gnt  = gnt[1];
  assign ex_done = (state == DONE) && (owner == REQ_EX);
  assign br_done = (state == DONE) && (owner == REQ_BR);
  assign is_zero = (state == DONE) && is_zero_r;
  assign busy    = (state != IDLE);

endmodule

// File: doc/zero_scan_sched.md
Name: zero_scan_sched

Overview:
- Iterative 64-bit zero-test controller shared by two pipeline clients: EX-stage flag logic (Z flag) and the CBZ/CBNZ branch unit.
- Owns one 16-bit NOR zero-detector instance and sequences it over the four 16-bit slices of a latched 64-bit operand.
- Exits early on the first non-zero slice.
- A 2-way round-robin arbiter shares the detector between the two requesters.

Parameters:
- DATA_W, 64, operand width; must be a multiple of SLICE_W.
- SLICE_W, 16, detector input width; fixed by the detector.
- NSLICE, DATA_W/SLICE_W = 4, slices per operand.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high.
- ex_req  in  1  EX requester wants a zero test.
- ex_data  in  64  EX operand; sampled only in the grant cycle.
- ex_gnt  out  1  one-cycle pulse: EX operand accepted.
- ex_done  out  1  one-cycle pulse: EX result valid.
- br_req  in  1  branch-unit request.
- br_data  in  64  branch operand; sampled only in the grant cycle.
- br_gnt  out  1  one-cycle pulse: branch operand accepted.
- br_done  out  1  one-cycle pulse: branch result valid.
- is_zero  out  1  result (1 = operand all zero); valid only while a done pulse is high.
- busy  out  1  high in SCAN and DONE.

Behaviour:
- Reset values: state=IDLE, idx=0, shadow=0, owner=EX, last_grant=BR (EX wins the first tie). All outputs are 0.
- Reset asserted in any state returns to IDLE next edge; an in-flight test is dropped with no done pulse.
- IDLE:
  - No request: stay in IDLE.
  - Any request: grant per round-robin. On a tie, the requester not equal to last_grant wins; a sole requester always wins.
  - In the grant cycle: gnt_x=1 (combinational from IDLE and the arbiter). At the edge: shadow<=x_data, owner<=x, last_grant<=x, idx<=0, state<=SCAN.
- SCAN:
  - Detector input = shadow[idx*16 +: 16]; its output zd is sampled at the clock edge of the same cycle.
  - zd=0: is_zero_r<=0, state<=DONE (early exit).
  - zd=1 and idx==NSLICE-1: is_zero_r<=1, state<=DONE.
  - Otherwise: idx<=idx+1.
  - Detector input is 16'h0000 outside SCAN.
- DONE (one cycle): done_owner=1, is_zero=is_zero_r; state<=IDLE unconditionally. A new grant occurs at the earliest in the following IDLE cycle.
- Latency, with grant in cycle T:
  - First slice non-zero: done in T+2.
  - Slice k (0-based) first non-zero: done in T+2+k.
  - All zero: done in T+5.
  - Minimum issue interval: 3 cycles. Maximum: 6 cycles.
- Requests during SCAN/DONE are not granted and are held pending by the requester. A requester drops req in the cycle after its gnt, or keeps it high to queue another test.
- Deassert before grant: legal, no effect. Deassert after grant: the test completes and done is still issued to the owner.
- Both requests held continuously: grants alternate EX, BR, EX, … with no starvation.
- ex_gnt/br_gnt mutually exclusive; ex_done/br_done mutually exclusive. Never gnt and done in the same cycle.
- Timing: detector delay is 10 time units (two gate levels at #5). The clock period must exceed it; bench uses period #100.

Decomposition:
- Package zero_scan_pkg:
  - state enum {IDLE, SCAN, DONE}.
  - Localparam NSLICE.
  - idx width $clog2(NSLICE).
  - Requester ID enum {REQ_EX, REQ_BR}.
- Sub-module rr_arb2:
  - Ports: req[1:0], last, en → gnt[1:0].
  - Purely combinational grant; last_grant register held in the parent.
- Existing 16-bit NOR zero detector instantiated once inside zero_scan_sched.

Test Plan:
- Reset held 3 cycles mid-SCAN (EX, operand 64'h0) → no ex_done; busy=0 and all outputs 0 after release; next request granted normally.
- EX alone, ex_data=64'h0000_0000_0000_0000 → ex_gnt at T, ex_done and is_zero=1 at T+5, br_done never.
- BR alone, br_data=64'h0000_0000_0000_0001 → br_done, is_zero=0 at T+2 (early exit on slice 0).
- EX, ex_data=64'h0001_0000_0000_0000 → is_zero=0 at T+5; ex_data=64'h0000_0000_8000_0000 → is_zero=0 at T+3.
- Both req held from reset, EX=64'h0, BR=64'hFFFF → grants EX, BR, EX, BR. Results 1,0,1,0; EX dones 5 cycles after grant, BR 2; gnt/done never overlap.
- br_req pulsed 1 cycle during an EX SCAN then dropped → no br_gnt. br_req deasserted the cycle after br_gnt → br_done still issued with the correct is_zero.
